// File: rtl/div_seq_pkg.sv
// Shared types and constants for the sequential MIPS divider.
package div_seq_pkg;

  localparam int unsigned Width = 32;
  localparam int unsigned CntW  = $clog2(Width);

  // Quotient reported when the divisor is zero.
  localparam logic [Width-1:0] DivZeroQuo = '1;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  function automatic logic [Width-1:0] cond_neg(input logic [Width-1:0] v, input logic neg);
    return neg ? (~v + Width'(1)) : v;
  endfunction

endpackage

// File: rtl/div_seq_if.sv
// Execute-stage handshake between the pipeline (master) and the divider (slave).
interface div_seq_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             startE;
  logic             signE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             flushE;
  logic             holdE;
  logic             stall_divE;
  logic             readyE;
  logic [WIDTH-1:0] hiE;
  logic [WIDTH-1:0] loE;
  logic             divzeroE;

  modport master (
    output startE, signE, srcaE, srcbE, flushE, holdE,
    input  stall_divE, readyE, hiE, loE, divzeroE
  );

  modport slave (
    input  startE, signE, srcaE, srcbE, flushE, holdE,
    output stall_divE, readyE, hiE, loE, divzeroE
  );

endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shifts the next dividend bit into the
// partial remainder and emits one quotient bit.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] trial;

  always_comb begin
    // Top bit of the widened difference is the borrow.
    trial = {rem_i, quo_i[WIDTH-1]} - {1'b0, div_i};
    if (trial[WIDTH]) begin
      rem_o = {rem_i[WIDTH-2:0], quo_i[WIDTH-1]};
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end else begin
      rem_o = trial[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Sequential MIPS DIV/DIVU unit: FSM, step counter and sign fix-up around div_step.
// Define DIV_EARLY_OUT_EN to finish divide-by-zero and |a| < |b| in one cycle.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int unsigned WIDTH = Width
) (
  input logic       clk,
  input logic       rst,
  div_seq_if.slave  dif
);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]  dvs_q, dvs_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic              dz_q, dz_d;

  logic              a_neg, b_neg, go, early, done;
  logic [WIDTH-1:0]  a_mag, b_mag, step_rem, step_quo;

  assign a_neg = dif.signE & dif.srcaE[WIDTH-1];
  assign b_neg = dif.signE & dif.srcbE[WIDTH-1];
  assign a_mag = cond_neg(dif.srcaE, a_neg);
  assign b_mag = cond_neg(dif.srcbE, b_neg);
  assign go    = (state_q == StIdle) & dif.startE & ~dif.flushE;
  assign done  = (state_q == StDone);

`ifdef DIV_EARLY_OUT_EN
  assign early = (dif.srcbE == '0) | (a_mag < b_mag);
`else
  assign early = 1'b0;
`endif

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          dz_d   = (dif.srcbE == '0);
          dvs_d  = b_mag;
          cnt_d  = '0;
          if (early) begin
            // Quotient is zero (or overridden); remainder is the dividend itself.
            rem_d   = a_mag;
            quo_d   = '0;
            state_d = StDone;
          end else begin
            rem_d   = '0;
            quo_d   = a_mag;
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StDone;
      end
      StDone: begin
        if (!dif.holdE) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (dif.flushE) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

  // Results are forced to zero outside DONE so reset and killed ops read as zero.
  always_comb begin
    dif.stall_divE = go | (state_q == StBusy);
    dif.readyE     = done;
    dif.divzeroE   = done & dz_q;
    dif.hiE        = '0;
    dif.loE        = '0;
    if (done) begin
      dif.hiE = cond_neg(rem_q, rneg_q);
      dif.loE = dz_q ? DivZeroQuo : cond_neg(quo_q, qneg_q);
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: vector table plus flush, hold and reset sequences.
module tb_div_seq;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    logic        early;
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  vec_t vecs[13];

  div_seq_if #(.WIDTH(32)) dif ();

  div_seq #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .dif (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a divide, waits (bounded) for readyE, returns results and timing.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic drop_start, output logic [31:0] lo,
                         output logic [31:0] hi, output logic dz, output int lat,
                         output int stalls, output logic got);
    dif.startE = 1'b1;
    dif.signE  = sgn;
    dif.srcaE  = a;
    dif.srcbE  = b;
    lat = 0;
    stalls = 0;
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      #1;
      if (dif.stall_divE) stalls++;
      tick();
      lat++;
      if (dif.readyE) got = 1'b1;
    end
    lo = dif.loE;
    hi = dif.hiE;
    dz = dif.divzeroE;
    if (drop_start) dif.startE = 1'b0;
  endtask

  initial begin
    logic [31:0] lo, hi;
    logic        dz, got;
    int          lat, stalls, exp_lat;
    n_cmp = 0;
    n_err = 0;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,        32'd14,       32'd2,        1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,      1'b0, 1'b0};
    vecs[3]  = '{1'b0, 32'd5,          32'd0,        32'hFFFF_FFFF, 32'd5,        1'b1, 1'b1};
    vecs[4]  = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,       1'b0, 1'b0};
    vecs[5]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd3,       32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 32'd0,        1'b0, 1'b0};
    vecs[7]  = '{1'b0, 32'd3,          32'd10,       32'd0,        32'd3,        1'b0, 1'b1};
    vecs[8]  = '{1'b1, 32'hFFFF_FFFD,  32'd10,       32'd0,        32'hFFFF_FFFD, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,       32'h8000_0000, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 32'hFFFF_FFF9,  32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 32'hDEAD_BEEF,  32'h0000_1234, 32'h000C_3BA5, 32'h0000_076B, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,       1'b0, 1'b0};

    rst        = 1'b1;
    dif.startE = 1'b0;
    dif.signE  = 1'b0;
    dif.srcaE  = '0;
    dif.srcbE  = '0;
    dif.flushE = 1'b0;
    dif.holdE  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset stall", 32'(dif.stall_divE), 32'd0);
    chk("reset ready", 32'(dif.readyE), 32'd0);
    chk("reset lo", dif.loE, 32'd0);
    chk("reset hi", dif.hiE, 32'd0);
    chk("reset divzero", 32'(dif.divzeroE), 32'd0);

    for (int i = 0; i < 13; i++) begin
`ifdef DIV_EARLY_OUT_EN
      exp_lat = vecs[i].early ? 1 : 33;
`else
      exp_lat = 33;
`endif
      run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, 1'b1, lo, hi, dz, lat, stalls, got);
      chk($sformatf("vec%0d ready", i), 32'(got), 32'd1);
      chk($sformatf("vec%0d lo", i), lo, vecs[i].lo);
      chk($sformatf("vec%0d hi", i), hi, vecs[i].hi);
      chk($sformatf("vec%0d divzero", i), 32'(dz), 32'(vecs[i].dz));
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(exp_lat));
      chk($sformatf("vec%0d stall cycles", i), 32'(stalls), 32'(exp_lat));
      chk($sformatf("vec%0d stall in done", i), 32'(dif.stall_divE), 32'd0);
      tick();
      chk($sformatf("vec%0d ready one cycle", i), 32'(dif.readyE), 32'd0);
    end

    // Flush at the tenth BUSY cycle kills the op.
    dif.startE = 1'b1;
    dif.signE  = 1'b0;
    dif.srcaE  = 32'd100;
    dif.srcbE  = 32'd7;
    tick();
    dif.startE = 1'b0;
    repeat (9) tick();
    chk("flush busy stall", 32'(dif.stall_divE), 32'd1);
    dif.flushE = 1'b1;
    tick();
    dif.flushE = 1'b0;
    #1;
    chk("flush idle stall", 32'(dif.stall_divE), 32'd0);
    got = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (dif.readyE) got = 1'b1;
    end
    chk("flush no ready", 32'(got), 32'd0);

    // Flush overrides a start request in IDLE.
    dif.startE = 1'b1;
    dif.flushE = 1'b1;
    #1;
    chk("flush over start stall", 32'(dif.stall_divE), 32'd0);
    tick();
    dif.startE = 1'b0;
    dif.flushE = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (dif.readyE) got = 1'b1;
    end
    chk("flush over start no ready", 32'(got), 32'd0);

    run_div(1'b0, 32'd100, 32'd7, 1'b1, lo, hi, dz, lat, stalls, got);
    chk("post flush lo", lo, 32'd14);
    chk("post flush hi", hi, 32'd2);
    chk("post flush latency", 32'(lat), 32'd33);
    tick();

    // Hold for four DONE cycles with startE still asserted.
    run_div(1'b0, 32'd100, 32'd7, 1'b0, lo, hi, dz, lat, stalls, got);
    chk("hold ready", 32'(got), 32'd1);
    dif.holdE = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) dif.holdE = 1'b0;
      #1;
      chk($sformatf("hold c%0d ready", i), 32'(dif.readyE), 32'd1);
      chk($sformatf("hold c%0d lo", i), dif.loE, 32'd14);
      chk($sformatf("hold c%0d hi", i), dif.hiE, 32'd2);
      chk($sformatf("hold c%0d stall", i), 32'(dif.stall_divE), 32'd0);
      tick();
    end
    dif.startE = 1'b0;
    #1;
    chk("hold exit ready", 32'(dif.readyE), 32'd0);
    got = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (dif.readyE || dif.stall_divE) got = 1'b1;
    end
    chk("hold no second divide", 32'(got), 32'd0);

    // Reset in the middle of BUSY.
    dif.startE = 1'b1;
    dif.srcaE  = 32'd5;
    dif.srcbE  = 32'd0;
    tick();
    dif.startE = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("rst busy stall", 32'(dif.stall_divE), 32'd0);
    chk("rst busy ready", 32'(dif.readyE), 32'd0);
    chk("rst busy lo", dif.loE, 32'd0);
    chk("rst busy hi", dif.hiE, 32'd0);
    chk("rst busy divzero", 32'(dif.divzeroE), 32'd0);
    rst = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (dif.readyE || dif.stall_divE) got = 1'b1;
    end
    chk("rst busy discarded", 32'(got), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; only 32 supported for MIPS HI/LO.
REQ-002 clk  input  1  rising-edge clock, sole clock.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 startE  input  1  divide instruction present in execute stage (mulOrdivE & divide op); level, held while stalled.
REQ-005 signE  input  1  1 = DIV (signed), 0 = DIVU; sampled with startE.
REQ-006 srcaE  input  WIDTH  dividend.
REQ-007 srcbE  input  WIDTH  divisor.
REQ-008 flushE  input  1  kill in-flight divide (exception/branch flush).
REQ-009 holdE  input  1  pipeline stalled by another source; result must persist.
REQ-010 stall_divE  output  1  stall request to hazard unit.
REQ-011 readyE  output  1  result valid this cycle, for HI/LO write (mdToHiloE).
REQ-012 hiE  output  WIDTH  remainder.
REQ-013 loE  output  WIDTH  quotient.
REQ-014 divzeroE  output  1  divisor was zero for the current result.

Function
REQ-015 States IDLE, BUSY, DONE; startE sampled only in IDLE.
REQ-016 IDLE & startE & !flushE -> BUSY; operands latched as magnitudes, signs and signE stored; counter = 0.
REQ-017 BUSY: one restoring shift-subtract step per cycle; after WIDTH steps (counter == WIDTH-1) -> DONE.
REQ-018 DONE & !holdE -> IDLE; DONE & holdE -> stay DONE, outputs stable.
REQ-019 Latency: startE cycle + 32 BUSY cycles; readyE first high 33 cycles after startE is first seen in IDLE.
REQ-020 stall_divE = (IDLE & startE & !flushE) | BUSY; low in DONE so the instruction advances at the end of DONE.
REQ-021 readyE high only in DONE; hiE/loE/divzeroE valid only while readyE; startE still high in DONE never restarts.
REQ-022 Signed: quotient negated when dividend and divisor signs differ; remainder takes dividend sign; 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-023 Divisor zero: lo=0xFFFFFFFF, hi=dividend (raw), divzeroE=1; same latency unless REQ-027 applies.
REQ-024 flushE in any state -> IDLE next cycle, readyE never asserted for the killed op; flushE overrides startE.

Reset
REQ-025 rst -> IDLE, counter=0, stall_divE=0, readyE=0, hiE=0, loE=0, divzeroE=0; rst mid-BUSY discards the op.
REQ-026 Reset is synchronous; no asynchronous path.

Configuration
REQ-027 DIV_EARLY_OUT_EN defined: a divisor of zero or a dividend magnitude below the divisor magnitude goes IDLE->DONE directly (readyE 1 cycle after start, stall 1 cycle), result per REQ-022/023 (lo=0, hi=dividend when |a|<|b|); undefined: all ops take the full REQ-019 latency.

Structure
REQ-028 Shared package: state enum, WIDTH constant, counter width (clog2(WIDTH)), divide-by-zero quotient constant.
REQ-029 Sub-module div_step: combinational single restoring iteration (partial remainder, quotient in) -> (partial remainder, quotient out); div_seq owns FSM, counter, sign fix-up.

Verification
REQ-030 DIVU 100/7, hold=0 -> stall_divE high 33 cycles, readyE 1 cycle, lo=14, hi=2.
REQ-031 DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-032 DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, divzeroE=1; with DIV_EARLY_OUT_EN readyE 1 cycle after start.
REQ-033 flushE at BUSY cycle 10 -> IDLE next cycle, stall_divE low, readyE never high; a fresh start then completes normally.
REQ-034 holdE high 4 cycles in DONE -> readyE and lo/hi stable 5 cycles, then IDLE; a startE held through DONE causes no second divide.
REQ-035 rst asserted mid-BUSY -> all outputs 0 next cycle, state IDLE.
